uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of byte-stream requesters (2..4).
REQ-002 SHALL have parameter TIMEOUT, default 1024: idle cycles within a packet before forced release.
REQ-003 SHALL have parameter GAP_CYCLES, default 4: idle cycles between packets (0 allowed).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  system clock (50MHz domain)
- reset  in  1  synchronous active-high reset
- req  in  NUM_PORTS  port i requests a packet slot
- in  in  8*NUM_PORTS  byte of port i at in[8*i+:8]
- inclk  in  NUM_PORTS  port i presents a byte this cycle
- last  in  NUM_PORTS  qualifies inclk[i]: final byte of packet
- ready  out  NUM_PORTS  port i may present a byte this cycle
- grant  out  NUM_PORTS  one-hot, port i owns the transmitter
- tx_ready  in  1  downstream uart stream driver requests a byte
- out  out  8  byte to downstream
- outclk  out  1  out valid, one-cycle pulse
- abort  out  1  one-cycle pulse on timeout release

Function
REQ-006 SHALL implement states IDLE, BUSY, GAP.
REQ-007 IDLE: if any req bit set, SHALL select the first requesting port strictly after last-served pointer (wrapping modulo NUM_PORTS), set grant one-hot, enter BUSY next cycle.
REQ-008 Last-served pointer SHALL reset to NUM_PORTS-1 so port 0 wins first; SHALL update to the granted port on entry to BUSY.
REQ-009 grant SHALL be zero in IDLE and GAP, exactly one-hot in BUSY.
REQ-010 ready[i] SHALL be combinational: tx_ready AND state==BUSY AND grant[i]; all other ready bits 0.
REQ-011 A byte SHALL be accepted only when inclk[i] AND ready[i]; inclk on any other port or while ready low SHALL be ignored (no outclk).
REQ-012 Accepted byte SHALL appear on out with outclk=1 exactly one cycle later (registered, latency 1); out holds value until next accept.
REQ-013 Accept with last[i]=1 SHALL clear grant next cycle and enter GAP (IDLE directly if GAP_CYCLES=0).
REQ-014 Deasserting req during BUSY SHALL NOT release grant; only last or timeout releases.
REQ-015 Timeout counter SHALL clear on entry to BUSY and on every accept, increment each other BUSY cycle; on reaching TIMEOUT-1 SHALL pulse abort for one cycle, clear grant, enter GAP.
REQ-016 Accept and timeout in same cycle: accept SHALL win, counter clears, no abort.
REQ-017 GAP SHALL last exactly GAP_CYCLES cycles, then IDLE; req ignored during GAP.
REQ-018 Counter widths SHALL use clog2 of parameter values; no wrap within legal range.

Reset
REQ-019 On reset: state IDLE, grant 0, outclk 0, abort 0, out 0, counters 0, pointer NUM_PORTS-1.
REQ-020 Reset mid-packet SHALL drop grant next cycle with no outclk or abort pulse; partial packet discarded.

Verification
REQ-021 req=2'b11 from reset, tx_ready=1, each port sends 3 bytes (last on 3rd) -> port 0 served first, GAP of 4 cycles, then port 1; outclk 6 pulses, byte order preserved.
REQ-022 Port 0 sends byte 8'hA5 with inclk while tx_ready=0 -> no outclk; resend with tx_ready=1 -> out=8'hA5, outclk one cycle after.
REQ-023 Port 1 granted, port 0 pulses inclk with 8'h3C -> ignored, outclk stays 0.
REQ-024 Port 0 granted, no inclk for TIMEOUT cycles -> abort single pulse at cycle TIMEOUT-1, grant 0, GAP, then port 1 granted if requesting.
REQ-025 Reset asserted after 2nd byte of 4-byte packet -> grant 0 next cycle, next packet after reset granted to port 0.
REQ-026 NUM_PORTS=4, only ports 1 and 3 request continuously -> grants alternate 1,3,1,3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one byte-stream requester at a time access to a
// downstream UART stream driver, with per-packet idle timeout and inter-packet gap.
module uart_tx_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int TIMEOUT    = 1024,
    parameter int GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req,
    input  logic [8*NUM_PORTS-1:0] in,
    input  logic [NUM_PORTS-1:0]   inclk,
    input  logic [NUM_PORTS-1:0]   last,
    output logic [NUM_PORTS-1:0]   ready,
    output logic [NUM_PORTS-1:0]   grant,
    input  logic                   tx_ready,
    output logic [7:0]             out,
    output logic                   outclk,
    output logic                   abort
);

    localparam int          PW = $clog2(NUM_PORTS);
    localparam int          TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int          GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned NP = NUM_PORTS;

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PTR_INIT = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    localparam state_t REL_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [GW-1:0]        gcnt_q, gcnt_d;
    logic [7:0]           out_q, out_d;
    logic                 outclk_q, outclk_d;
    logic                 abort_q, abort_d;

    logic [PW-1:0]        pick_idx;
    logic [PW-1:0]        cand_idx;
    logic                 pick_found;
    logic [7:0]           sel_byte;
    logic                 sel_last;
    logic                 accept;

    assign ready  = (state_q == BUSY && tx_ready) ? grant_q : '0;
    assign accept = |(inclk & ready);
    assign grant  = grant_q;
    assign out    = out_q;
    assign outclk = outclk_q;
    assign abort  = abort_q;

    // Search starts one past the last-served port and wraps, so the owner of
    // the previous packet has the lowest priority for the next one.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand_idx   = ptr_q;
        for (int unsigned k = 1; k <= NP; k++) begin
            cand_idx = PW'((int'(ptr_q) + k) % NP);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (grant_q[i]) begin
                sel_byte = sel_byte | in[8*i +: 8];
                sel_last = sel_last | last[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        tcnt_d   = tcnt_q;
        gcnt_d   = gcnt_q;
        out_d    = out_q;
        outclk_d = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
                    ptr_d   = pick_idx;
                    tcnt_d  = '0;
                end
            end
            BUSY: begin
                // An accept on the final timeout cycle still counts as activity.
                if (accept) begin
                    out_d    = sel_byte;
                    outclk_d = 1'b1;
                    tcnt_d   = '0;
                    if (sel_last) begin
                        grant_d = '0;
                        gcnt_d  = '0;
                        state_d = REL_STATE;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    gcnt_d  = '0;
                    state_d = REL_STATE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    gcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= PTR_INIT;
            tcnt_q   <= '0;
            gcnt_q   <= '0;
            out_q    <= '0;
            outclk_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            tcnt_q   <= tcnt_d;
            gcnt_q   <= gcnt_d;
            out_q    <= out_d;
            outclk_q <= outclk_d;
            abort_q  <= abort_d;
        end
    end

endmodule
